sort_stack_kv: RTL and testbench

Parametrised systolic priority sorter that accepts key/tag pairs and emits them in sorted order. It generalises the original sorting stack with a separate tag payload, valid/ready handshakes on both sides, occupancy and full/empty status, a run-time ascending/descending order, synchronous clear, and an asynchronous reset. It sits between a producer stream and a consumer that needs the current extreme element, for example scheduling or top-K selection. It supports one insertion and one removal per clock.

---
 rtl/sort_stack_kv_pkg.sv | 24 ++
 rtl/sort_stack_kv_slot.sv | 59 +++++
 rtl/sort_stack_kv.sv | 149 ++++++++++++++
 tb/tb_sort_stack_kv.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_stack_kv_pkg.sv
// ============================================================================
// sort_pkg : shared helpers for the sort_stack_kv priority sorter
// Rev 1.0
// ============================================================================
`default_nettype none

package sort_pkg;

    localparam int KEY_MAX_W = 64;

    typedef logic [KEY_MAX_W-1:0] key_ext_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Strict comparison, so equal keys never overtake each other.
    function automatic logic is_better(input key_ext_t a, input key_ext_t b, input logic order);
        return order ? (a > b) : (a < b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort_stack_kv_slot.sv
// ============================================================================
// sort_slot : one storage slot of the systolic sorter with its next-state mux
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_slot #(
    parameter int KEY_W = 32,
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upper_occ,
    input  logic [KEY_W-1:0] upper_key,
    input  logic [TAG_W-1:0] upper_tag,
    input  logic             lower_occ,
    input  logic [KEY_W-1:0] lower_key,
    input  logic [TAG_W-1:0] lower_tag,
    input  logic [KEY_W-1:0] new_key,
    input  logic [TAG_W-1:0] new_tag,
    input  logic             insert,
    input  logic             shift,
    input  logic             pop,
    input  logic             clear,
    output logic             occ,
    output logic [KEY_W-1:0] key,
    output logic [TAG_W-1:0] tag
);

    // A shift combined with a pop cancels out, so the slot keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 1'b0;
            key <= '0;
            tag <= '0;
        end else if (clear) begin
            occ <= 1'b0;
            key <= '0;
            tag <= '0;
        end else if (insert) begin
            occ <= 1'b1;
            key <= new_key;
            tag <= new_tag;
        end else if (shift) begin
            if (!pop) begin
                occ <= upper_occ;
                key <= upper_key;
                tag <= upper_tag;
            end
        end else if (pop) begin
            occ <= lower_occ;
            key <= lower_key;
            tag <= lower_tag;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sort_stack_kv.sv
// ============================================================================
// sort_stack_kv : key/tag priority sorter, one push and one pop per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_stack_kv
    import sort_pkg::*;
#(
    parameter int KEY_W = 32,
    parameter int TAG_W = 16,
    parameter int DEPTH = 64,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             clear,
    input  logic             descend,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] occ;
    logic [KEY_W-1:0] key [DEPTH];
    logic [TAG_W-1:0] tag [DEPTH];
    logic [DEPTH-1:0] sh_occ;
    logic [KEY_W-1:0] sh_key [DEPTH];
    logic [DEPTH-1:0] cond;
    logic [DEPTH-1:0] ins;
    logic [DEPTH-1:0] shift;
    logic             order_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign in_ready  = !hold && (!full || out_ready);
    assign out_valid = !hold && !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_key   = key[0];
    assign out_tag   = tag[0];
    assign count     = cnt_q;

    // Insertion point is searched in the array as it looks after any pop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        if (i < DEPTH - 1) begin : g_mid
            assign sh_occ[i] = pop ? occ[i+1] : occ[i];
            assign sh_key[i] = pop ? key[i+1] : key[i];
        end else begin : g_last
            assign sh_occ[i] = pop ? 1'b0 : occ[i];
            assign sh_key[i] = pop ? '0 : key[i];
        end
        assign cond[i] = !sh_occ[i] ||
                         is_better(key_ext_t'(in_key), key_ext_t'(sh_key[i]), order_q);
    end

    always_comb begin : p_select
        logic found;
        found = 1'b0;
        ins   = '0;
        shift = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ins[i]   = push && cond[i] && !found;
            shift[i] = push && found;
            found    = found || cond[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            order_q <= 1'b1;
        end else if (clear) begin
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (push && empty) begin
                order_q <= descend;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             up_occ;
        logic [KEY_W-1:0] up_key;
        logic [TAG_W-1:0] up_tag;
        logic             lo_occ;
        logic [KEY_W-1:0] lo_key;
        logic [TAG_W-1:0] lo_tag;

        if (i == 0) begin : g_head
            assign up_occ = 1'b0;
            assign up_key = '0;
            assign up_tag = '0;
        end else begin : g_body
            assign up_occ = occ[i-1];
            assign up_key = key[i-1];
            assign up_tag = tag[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign lo_occ = 1'b0;
            assign lo_key = '0;
            assign lo_tag = '0;
        end else begin : g_inner
            assign lo_occ = occ[i+1];
            assign lo_key = key[i+1];
            assign lo_tag = tag[i+1];
        end

        sort_slot #(
            .KEY_W(KEY_W),
            .TAG_W(TAG_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .upper_occ(up_occ),
            .upper_key(up_key),
            .upper_tag(up_tag),
            .lower_occ(lo_occ),
            .lower_key(lo_key),
            .lower_tag(lo_tag),
            .new_key  (in_key),
            .new_tag  (in_tag),
            .insert   (ins[i]),
            .shift    (shift[i]),
            .pop      (pop),
            .clear    (clear),
            .occ      (occ[i]),
            .key      (key[i]),
            .tag      (tag[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_sort_stack_kv.sv
// ============================================================================
// tb_sort_stack_kv : directed table-driven bench for sort_stack_kv (DEPTH = 8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sort_stack_kv;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold = 1'b0;
    logic             clear = 1'b0;
    logic             descend = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_key = '0;
    logic [15:0]      in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_key;
    logic [15:0]      out_tag;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             push;
        logic             pop;
        logic             desc;
        logic [31:0]      key;
        logic [15:0]      tag;
        logic             ev;
        logic [31:0]      ek;
        logic [15:0]      et;
        logic [CNT_W-1:0] ec;
    } vec_t;

    vec_t tbl[$];

    sort_stack_kv #(
        .KEY_W(32),
        .TAG_W(16),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .clear    (clear),
        .descend  (descend),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_key   (in_key),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_key  (out_key),
        .out_tag  (out_tag),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int p, input int q, input int d, input int k, input int t,
                                input int ev, input int ek, input int et, input int ec);
        vec_t v;
        v.push = p[0];
        v.pop  = q[0];
        v.desc = d[0];
        v.key  = 32'(k);
        v.tag  = 16'(t);
        v.ev   = ev[0];
        v.ek   = 32'(ek);
        v.et   = 16'(et);
        v.ec   = CNT_W'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic q, input logic d,
                         input logic [31:0] k, input logic [15:0] t);
        @(negedge clk);
        in_valid  = p;
        out_ready = q;
        descend   = d;
        in_key    = k;
        in_tag    = t;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        // Descending order, pops drain largest first
        tbl.push_back(mk(1, 0, 1, 5, 'h15, 1, 5, 'h15, 1));
        tbl.push_back(mk(1, 0, 1, 9, 'h19, 1, 9, 'h19, 2));
        tbl.push_back(mk(1, 0, 1, 1, 'h11, 1, 9, 'h19, 3));
        tbl.push_back(mk(1, 0, 1, 7, 'h17, 1, 9, 'h19, 4));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 7, 'h17, 3));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 5, 'h15, 2));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 1, 'h11, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
        // Ascending order, equal keys leave in arrival order
        tbl.push_back(mk(1, 0, 0, 3, 'hA, 1, 3, 'hA, 1));
        tbl.push_back(mk(1, 0, 0, 3, 'hB, 1, 3, 'hA, 2));
        tbl.push_back(mk(1, 0, 0, 2, 'hC, 1, 2, 'hC, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 'hA, 2));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 3, 'hB, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        // Fill to capacity in descending order
        for (int k = 1; k <= DEPTH; k++) begin
            tbl.push_back(mk(1, 0, 1, k * 10, 'h100 + k, 1, k * 10, 'h100 + k, k));
        end

        // Reset state
        #12;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_key", 64'(out_key), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        foreach (tbl[i]) begin
            drive(tbl[i].push, tbl[i].pop, tbl[i].desc, tbl[i].key, tbl[i].tag);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].ec));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_out_key", i), 64'(out_key), 64'(tbl[i].ek));
                chk($sformatf("vec%0d_out_tag", i), 64'(out_tag), 64'(tbl[i].et));
            end
        end

        // Full: push blocked alone, accepted together with a pop
        @(negedge clk);
        in_valid  = 1'b1;
        in_key    = 100;
        in_tag    = 'h1FF;
        descend   = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("full_flag", 64'(full), 64'(1));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 64'(in_ready), 64'(1));
        chk("full_pop_old_head", 64'(out_key), 64'(80));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("full_new_head", 64'(out_key), 64'(100));
        chk("full_new_tag", 64'(out_tag), 64'('h1FF));
        chk("full_count", 64'(count), 64'(8));
        drive(1'b0, 1'b1, 1'b1, 32'd0, 16'd0);
        chk("full_after_pop_head", 64'(out_key), 64'(70));
        chk("full_after_pop_count", 64'(count), 64'(7));

        // Hold freezes everything; clear wins over hold
        @(negedge clk);
        hold      = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_key    = 1;
        #1;
        chk("hold_in_ready", 64'(in_ready), 64'(0));
        chk("hold_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("hold_count", 64'(count), 64'(7));
        chk("hold_head", 64'(out_key), 64'(70));
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_count", 64'(count), 64'(0));
        chk("clear_empty", 64'(empty), 64'(1));
        chk("clear_out_key", 64'(out_key), 64'(0));
        chk("clear_out_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        clear     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Order latches on the first push; later descend changes are ignored
        drive(1'b1, 1'b0, 1'b0, 32'd5, 16'h5);
        drive(1'b1, 1'b0, 1'b1, 32'd3, 16'h3);
        chk("order_head_a", 64'(out_key), 64'(3));
        drive(1'b1, 1'b0, 1'b1, 32'd4, 16'h4);
        chk("order_head_b", 64'(out_key), 64'(3));
        chk("order_count", 64'(count), 64'(3));
        drive(1'b0, 1'b1, 1'b1, 32'd0, 16'd0);
        chk("order_after_pop", 64'(out_key), 64'(4));

        // Simultaneous push and pop on a single-entry stack
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd4, 16'h44);
        chk("pp_head_before", 64'(out_key), 64'(4));
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_key    = 6;
        in_tag    = 'h66;
        #1;
        chk("pp_head_during", 64'(out_key), 64'(4));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_head_after", 64'(out_key), 64'(6));
        chk("pp_tag_after", 64'(out_tag), 64'('h66));
        chk("pp_count", 64'(count), 64'(1));

        // Asynchronous reset with entries stored
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(20 + k), 16'(k));
        end
        chk("ar_count_before", 64'(count), 64'(5));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'(0));
        chk("ar_count", 64'(count), 64'(0));
        chk("ar_empty", 64'(empty), 64'(1));
        chk("ar_out_key", 64'(out_key), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_in_ready", 64'(in_ready), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
